// File: rtl/sm_decoder_if.sv
// Pixel-memory read port and pixel output stream of the sparse-map decoder.
// The master side is the decoder; the slave side is the memory arbiter plus consumer.
interface sm_decoder_if;
  logic        pxMem_RD_VLD;
  logic        pxMem_RD_RDY;
  logic        pxMem_GRANT;
  logic        pxMem_RD_REQ;
  logic [15:0] pxMem_Addr;
  logic [4:0]  px_burst;
  logic [15:0] pxMem_in;
  logic        px_RDY;
  logic        px_VLD;
  logic [15:0] px_value_out;
  logic [9:0]  px_row;
  logic [15:0] px_col;

  modport master (
    input  pxMem_RD_VLD, pxMem_GRANT, pxMem_in, px_RDY,
    output pxMem_RD_RDY, pxMem_RD_REQ, pxMem_Addr, px_burst,
    output px_VLD, px_value_out, px_row, px_col
  );

  modport slave (
    output pxMem_RD_VLD, pxMem_GRANT, pxMem_in, px_RDY,
    input  pxMem_RD_RDY, pxMem_RD_REQ, pxMem_Addr, px_burst,
    input  px_VLD, px_value_out, px_row, px_col
  );
endinterface

// File: rtl/sm_decoder.sv
// Sparse-map decoder: reads a 16-bit sparsity map, burst-reads its non-zero values and
// streams them out tagged with (row, col). Zero pixels are never emitted.
module sm_decoder (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [15:0]    start_address,
  input  logic [9:0]     start_row,
  input  logic [15:0]    start_col,
  input  logic           op_start,
  output logic           busy,
  sm_decoder_if.master   bus
);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StSetup   = 4'd1;
  localparam logic [3:0] StGrantSm = 4'd2;
  localparam logic [3:0] StCmdSm   = 4'd3;
  localparam logic [3:0] StRecvSm  = 4'd4;
  localparam logic [3:0] StHamming = 4'd5;
  localparam logic [3:0] StSave    = 4'd6;
  localparam logic [3:0] StGrantNz = 4'd7;
  localparam logic [3:0] StCmdNz   = 4'd8;
  localparam logic [3:0] StRecvNz  = 4'd9;
  localparam logic [3:0] StMove    = 4'd10;

  logic [3:0]  state_q;
  logic [15:0] sa_q, nz_addr_q, col_q, sm_q, rem_q;
  logic [9:0]  row_q;
  logic [4:0]  count_q, burst_q, rcv_q;
  logic [1:0]  nib_q;
  logic [3:0]  out_q;
  logic [15:0] nz_buf_q [16];

  logic [3:0]  nibble;
  logic [3:0]  lsb_idx;

  assign nibble = sm_q[{nib_q, 2'b00} +: 4];

  // Lowest remaining set bit of the map is the position of the next pixel to emit.
  always_comb begin
    lsb_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (rem_q[i]) lsb_idx = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sa_q      <= '0;
      nz_addr_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      sm_q      <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      burst_q   <= '0;
      rcv_q     <= '0;
      nib_q     <= '0;
      out_q     <= '0;
      for (int i = 0; i < 16; i++) nz_buf_q[i] <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (op_start) begin
            sa_q    <= start_address;
            row_q   <= start_row;
            col_q   <= start_col;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          nz_addr_q <= sa_q + 16'd1;
          state_q   <= StGrantSm;
        end
        StGrantSm: if (bus.pxMem_GRANT) state_q <= StCmdSm;
        StCmdSm:   state_q <= StRecvSm;
        StRecvSm: begin
          if (bus.pxMem_RD_VLD) begin
            sm_q    <= bus.pxMem_in;
            count_q <= '0;
            nib_q   <= '0;
            state_q <= StHamming;
          end
        end
        StHamming: begin
          count_q <= count_q + {4'd0, nibble[0]} + {4'd0, nibble[1]}
                             + {4'd0, nibble[2]} + {4'd0, nibble[3]};
          nib_q   <= nib_q + 2'd1;
          if (nib_q == 2'd3) state_q <= StSave;
        end
        StSave: begin
          burst_q <= count_q;
          rcv_q   <= '0;
          out_q   <= '0;
          rem_q   <= sm_q;
          state_q <= (count_q == 5'd0) ? StIdle : StGrantNz;
        end
        StGrantNz: if (bus.pxMem_GRANT) state_q <= StCmdNz;
        StCmdNz:   state_q <= StRecvNz;
        StRecvNz: begin
          if (bus.pxMem_RD_VLD) begin
            nz_buf_q[rcv_q[3:0]] <= bus.pxMem_in;
            rcv_q                <= rcv_q + 5'd1;
            if (rcv_q + 5'd1 == burst_q) state_q <= StMove;
          end
        end
        StMove: begin
          if (bus.px_RDY) begin
            rem_q[lsb_idx] <= 1'b0;
            out_q          <= out_q + 4'd1;
            // Only one set bit left means this handshake was the last pixel.
            if ((rem_q & (rem_q - 16'd1)) == 16'd0) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy              = (state_q != StIdle);
    bus.pxMem_RD_REQ  = 1'b0;
    bus.pxMem_RD_RDY  = 1'b0;
    bus.pxMem_Addr    = '0;
    bus.px_burst      = '0;
    bus.px_VLD        = 1'b0;
    bus.px_value_out  = '0;
    bus.px_row        = '0;
    bus.px_col        = '0;
    case (state_q)
      StGrantSm, StCmdSm, StRecvSm: begin
        bus.pxMem_RD_REQ = (state_q != StRecvSm);
        bus.pxMem_RD_RDY = (state_q == StRecvSm);
        bus.pxMem_Addr   = sa_q;
        bus.px_burst     = 5'd1;
      end
      StGrantNz, StCmdNz, StRecvNz: begin
        bus.pxMem_RD_REQ = (state_q != StRecvNz);
        bus.pxMem_RD_RDY = (state_q == StRecvNz);
        bus.pxMem_Addr   = nz_addr_q;
        bus.px_burst     = burst_q;
      end
      StMove: begin
        bus.px_VLD       = 1'b1;
        bus.px_value_out = nz_buf_q[out_q];
        bus.px_row       = row_q;
        bus.px_col       = col_q + {12'd0, lsb_idx};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sm_decoder.sv
// Self-checking bench for sm_decoder: directed table of operations plus randomized
// operations, each checked against a list-based model of the expected reads and pixels.
module tb_sm_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] start_address;
  logic [9:0]  start_row;
  logic [15:0] start_col;
  logic        op_start;
  logic        busy;

  sm_decoder_if bus ();

  sm_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_address (start_address),
    .start_row     (start_row),
    .start_col     (start_col),
    .op_start      (op_start),
    .busy          (busy),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sa;
    logic [9:0]  row;
    logic [15:0] col;
    logic [15:0] sm;
    int          gdelay;
    int          stall_pct;
    bit          abort_nz;
    logic [4:0]  exp_pop;
    logic [15:0] exp_nz_addr;
    logic [15:0] exp_last_col;
  } vec_t;

  typedef struct {
    logic [15:0] value;
    logic [9:0]  row;
    logic [15:0] col;
  } pix_t;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] mem [65536];
  logic [15:0] req_addr[$];
  logic [4:0]  req_burst[$];
  pix_t        pix_obs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int popcount(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic check_idle(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_mem"}, {bus.pxMem_RD_REQ, bus.pxMem_RD_RDY, bus.pxMem_Addr, bus.px_burst},
          64'd0);
    check({name, "_px"}, {bus.px_VLD, bus.px_value_out, bus.px_row, bus.px_col}, 64'd0);
  endtask

  task automatic run_op(input vec_t v);
    int          cyc = 0, waited = 0, j = 0, unstable = 0, early_rdy = 0, req_drop = 0;
    bit          prev_rdy = 0, prev_vld = 0, prev_prdy = 0, prev_req = 0, prev_grant = 0;
    bit          aborted = 0, vld;
    pix_t        cur, prev_pix;
    logic [15:0] cur_addr = '0, a;
    logic [4:0]  cur_burst = '0;
    pix_t        exp_pix[$];
    int          pop, k;

    mem[v.sa] = v.sm;
    for (int i = 1; i <= 16; i++) begin
      a = v.sa + 16'(i);
      mem[a] = 16'($urandom_range(1, 65535));
    end
    req_addr.delete();
    req_burst.delete();
    pix_obs.delete();

    @(negedge clk);
    start_address = v.sa;
    start_row     = v.row;
    start_col     = v.col;
    op_start      = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);

    while (busy && cyc < 3000) begin
      if (bus.pxMem_RD_REQ && bus.pxMem_RD_RDY) early_rdy++;
      if (prev_req && !prev_grant && !bus.pxMem_RD_REQ) req_drop++;
      prev_req = bus.pxMem_RD_REQ;
      if (bus.pxMem_RD_REQ) begin
        if (waited >= v.gdelay) bus.pxMem_GRANT = 1'b1;
        else begin
          bus.pxMem_GRANT = 1'b0;
          waited++;
        end
      end else begin
        bus.pxMem_GRANT = 1'b0;
        waited = 0;
      end
      prev_grant = bus.pxMem_GRANT;

      if (bus.pxMem_RD_RDY) begin
        if (!prev_rdy) begin
          req_addr.push_back(bus.pxMem_Addr);
          req_burst.push_back(bus.px_burst);
          cur_addr  = bus.pxMem_Addr;
          cur_burst = bus.px_burst;
          j = 0;
        end else if (bus.pxMem_Addr !== cur_addr || bus.px_burst !== cur_burst) unstable++;
        if (v.abort_nz && req_addr.size() == 2) begin
          rst_n = 1'b0;
          aborted = 1;
          break;
        end
        vld = ($urandom % 4) != 0;
        a = cur_addr + 16'(j);
        bus.pxMem_RD_VLD = vld;
        bus.pxMem_in     = mem[a];
        if (vld) j++;
      end else begin
        // Junk that the decoder must ignore outside its receive states.
        bus.pxMem_RD_VLD = ($urandom % 3) == 0;
        bus.pxMem_in     = 16'($urandom);
      end
      prev_rdy = bus.pxMem_RD_RDY;

      if (bus.px_VLD) begin
        cur.value = bus.px_value_out;
        cur.row   = bus.px_row;
        cur.col   = bus.px_col;
        if (prev_vld && !prev_prdy && cur != prev_pix) unstable++;
        bus.px_RDY = int'($urandom % 100) >= v.stall_pct;
        if (bus.px_RDY) pix_obs.push_back(cur);
        prev_pix = cur;
      end else begin
        bus.px_RDY = $urandom % 2;
      end
      prev_vld  = bus.px_VLD;
      prev_prdy = bus.px_RDY;

      op_start      = ($urandom % 4) == 0;
      start_address = 16'($urandom);
      start_row     = 10'($urandom);
      start_col     = 16'($urandom);
      @(negedge clk);
      cyc++;
    end
    op_start         = 1'b0;
    bus.pxMem_RD_VLD = 1'b0;
    bus.pxMem_GRANT  = 1'b0;
    bus.px_RDY       = 1'b0;
    check("op_timeout", 64'(cyc < 3000), 64'd1);

    if (aborted) begin
      @(negedge clk);
      check_idle("abort");
      rst_n = 1'b1;
      return;
    end
    check_idle("op_end");

    pop = popcount(v.sm);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (v.sm[i]) begin
        a = v.sa + 16'(1 + k);
        cur.value = mem[a];
        cur.row   = v.row;
        cur.col   = v.col + 16'(i);
        exp_pix.push_back(cur);
        k++;
      end
    end

    check("req_count", 64'(req_addr.size()), (pop == 0) ? 64'd1 : 64'd2);
    if (req_addr.size() >= 1) begin
      check("sm_addr", 64'(req_addr[0]), 64'(v.sa));
      check("sm_burst", 64'(req_burst[0]), 64'd1);
    end
    if (pop != 0 && req_addr.size() >= 2) begin
      a = v.sa + 16'd1;
      check("nz_addr", 64'(req_addr[1]), 64'(a));
      check("nz_burst", 64'(req_burst[1]), 64'(pop));
    end
    check("pix_count", 64'(pix_obs.size()), 64'(pop));
    for (int i = 0; i < pop && i < pix_obs.size(); i++) begin
      check("pix", {pix_obs[i].value, pix_obs[i].row, pix_obs[i].col},
            {exp_pix[i].value, exp_pix[i].row, exp_pix[i].col});
    end
    check("hold_stable", 64'(unstable), 64'd0);
    check("rdy_before_grant", 64'(early_rdy), 64'd0);
    check("req_dropped", 64'(req_drop), 64'd0);

    // Hand-computed expectations from the directed table.
    check("tbl_pop", (req_burst.size() >= 2) ? 64'(req_burst[1]) : 64'd0, 64'(v.exp_pop));
    if (v.exp_pop != 0) begin
      check("tbl_nz_addr", (req_addr.size() >= 2) ? 64'(req_addr[1]) : 64'hdead,
            64'(v.exp_nz_addr));
      check("tbl_last_col", (pix_obs.size() > 0) ? 64'(pix_obs[pix_obs.size()-1].col) : 64'hdead,
            64'(v.exp_last_col));
    end
  endtask

  initial begin
    vec_t tbl [6];
    vec_t rv;
    int   r;

    //        sa        row  col        sm        gd st ab pop  nz_addr   last_col
    tbl[0] = '{16'hF7F7, 600, 16'd5000, 16'h0F55, 0, 0, 0, 8,   16'hF7F8, 16'd5011};
    tbl[1] = '{16'h0200, 3,   16'd40,   16'h0000, 1, 0, 0, 0,   16'h0000, 16'd0};
    tbl[2] = '{16'h0100, 5,   16'd10,   16'h8001, 0, 70, 0, 2,  16'h0101, 16'd25};
    tbl[3] = '{16'h1234, 77,  16'd100,  16'hFFFF, 5, 20, 0, 16, 16'h1235, 16'd115};
    tbl[4] = '{16'hFFFF, 1023, 16'hFFFE, 16'h000C, 2, 0, 0, 2, 16'h0000, 16'h0001};
    tbl[5] = '{16'h4000, 9,   16'd0,    16'h00F0, 0, 0, 1, 0,   16'h0000, 16'd0};

    rst_n            = 1'b0;
    op_start         = 1'b0;
    start_address    = '0;
    start_row        = '0;
    start_col        = '0;
    bus.pxMem_RD_VLD = 1'b0;
    bus.pxMem_GRANT  = 1'b0;
    bus.pxMem_in     = '0;
    bus.px_RDY       = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_op(tbl[i]);

    for (int n = 0; n < 25; n++) begin
      r = $urandom % 8;
      rv.sa        = 16'($urandom);
      rv.row       = 10'($urandom);
      rv.col       = 16'($urandom);
      rv.sm        = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
      rv.gdelay    = $urandom_range(0, 6);
      rv.stall_pct = $urandom_range(0, 60);
      rv.abort_nz  = 0;
      rv.exp_pop   = 5'(popcount(rv.sm));
      rv.exp_nz_addr = rv.sa + 16'd1;
      rv.exp_last_col = '0;
      for (int b = 0; b < 16; b++) if (rv.sm[b]) rv.exp_last_col = rv.col + 16'(b);
      run_op(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
